// File: rtl/spi_ram_host.sv
// spi_ram_host: SPI master that serialises RAM commands into 11-bit frames and captures read-data replies
//   clk, rst          system clock, synchronous active-high reset
//   req_valid/ready   command handshake; req_op selects the command, req_data the address/data byte
//   rsp_valid/data    one-cycle pulse carrying the byte read back from MISO
//   busy              frame or inter-frame gap in progress
//   ss_n, MOSI, MISO  serial interface to the slave subsystem
module spi_ram_host #(
  parameter int TURN_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       ss_n,
  output logic       MOSI,
  input  logic       MISO
);
  typedef enum logic [2:0] {IDLE, SHIFT, TURN, CAPTURE, GAP} state_e;
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
  state_e      state_q;
  logic [10:0] shift_q;
  logic [3:0]  cnt_q;
  logic [6:0]  cap_q;
  logic [7:0]  rsp_data_q;
  logic        ss_n_q, rsp_valid_q, rd_q;
  assign req_ready = (state_q == IDLE) && !rst;
  assign busy      = state_q != IDLE;
  assign ss_n      = ss_n_q;
  // Zero fill means the register is all-zero once the frame has shifted out,
  // so MOSI is low everywhere outside SHIFT without extra gating.
  assign MOSI      = shift_q[10];
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      ss_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          state_q <= SHIFT;
          shift_q <= {req_op[1], req_op, (req_op == 2'b11) ? 8'h00 : req_data};
          rd_q    <= req_op == 2'b11;
          ss_n_q  <= 1'b0;
          cnt_q   <= 4'd10;
        end
        SHIFT: begin
          shift_q <= {shift_q[9:0], 1'b0};
          if (cnt_q == 4'd0) begin
            state_q <= rd_q ? TURN : GAP;
            ss_n_q  <= !rd_q;
            cnt_q   <= rd_q ? TURN_LAST : GAP_LAST;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        TURN: begin
          state_q <= (cnt_q == 4'd0) ? CAPTURE : TURN;
          cnt_q   <= (cnt_q == 4'd0) ? 4'd7 : cnt_q - 4'd1;
        end
        CAPTURE: begin
          cap_q <= {cap_q[5:0], MISO};
          if (cnt_q == 4'd0) begin
            rsp_data_q  <= {cap_q, MISO};
            rsp_valid_q <= 1'b1;
            state_q     <= GAP;
            ss_n_q      <= 1'b1;
            cnt_q       <= GAP_LAST;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        GAP: begin
          state_q <= (cnt_q == 4'd0) ? IDLE : GAP;
          cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_ram_host.sv
// tb_spi_ram_host: randomized scoreboard bench for spi_ram_host over three TURN/GAP configurations
module tb_spi_ram_host;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  function automatic void chk(input int g, input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %0d expected %0d", g, nm, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int TC = (g == 1) ? 1 : (g == 2) ? 4 : 2;
    localparam int GC = (g == 0) ? 1 : 3;
    logic       rst, req_valid, req_ready, rsp_valid, busy, ss_n, mosi;
    logic       miso = 1'b0;
    logic [1:0] req_op;
    logic [7:0] req_data, rsp_data;
    logic [7:0] rsp_q[$];
    logic [10:0] frm_q[$];
    logic [7:0] ref_mem[256];
    logic [7:0] sl_mem[256];
    logic [7:0] ref_addr, sl_addr;
    logic [7:0] reply = 8'h00;
    logic [7:0] last = 8'h00;
    logic [7:0] e8;
    logic [10:0] ef;
    logic [10:0] bits = '0;
    int idx = 0, gcnt = 0, hi = 0;
    bit mbad = 0, prev_rv = 0, seen = 0;

    spi_ram_host #(.TURN_CYCLES(TC), .GAP_CYCLES(GC)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .busy(busy), .ss_n(ss_n), .MOSI(mosi), .MISO(miso)
    );

    // Slave model and monitor: decodes frames from MOSI, answers reads on MISO,
    // and checks frames, gaps and responses against the queued expectations.
    always @(negedge clk) begin
      if (rst) begin
        idx = 0; gcnt = 0; hi = 0; seen = 0; mbad = 0; prev_rv = 0; last = 8'h00;
        miso = 1'($urandom);
      end else begin
        if (!ss_n) begin
          if (idx == 0 && seen) chk(g, "gap_min", int'(hi >= GC), 1);
          hi = 0;
          if (idx < 11) bits = {bits[9:0], mosi};
          else mbad |= mosi;
          if (idx == 10) begin
            case (bits[9:8])
              2'b00, 2'b10: sl_addr = bits[7:0];
              2'b01: sl_mem[sl_addr] = bits[7:0];
              default: reply = sl_mem[sl_addr];
            endcase
          end
          miso = (idx >= 11 + TC && idx < 19 + TC) ? reply[18 + TC - idx] : 1'($urandom);
          idx++;
        end else begin
          mbad |= mosi;
          if (idx != 0) begin
            if (frm_q.size() == 0) chk(g, "frame_unexpected", 1, 0);
            else begin
              ef = frm_q.pop_front();
              chk(g, "frame_bits", bits, ef);
              chk(g, "frame_len", idx, (ef[9:8] == 2'b11) ? 19 + TC : 11);
            end
            chk(g, "mosi_zero", mbad, 0);
            mbad = 0; seen = 1; idx = 0;
          end
          hi++;
          miso = 1'($urandom);
        end
        if (ss_n && busy) gcnt++;
        if (!busy && gcnt != 0) begin
          chk(g, "gap_len", gcnt, GC);
          gcnt = 0;
        end
        if (rsp_valid) begin
          chk(g, "rsp_pulse_width", prev_rv, 0);
          if (rsp_q.size() == 0) chk(g, "rsp_unexpected", 1, 0);
          else begin
            e8 = rsp_q.pop_front();
            chk(g, "rsp_data", rsp_data, e8);
            last = e8;
          end
        end else if (rsp_data != last) chk(g, "rsp_hold", rsp_data, last);
        prev_rv = rsp_valid;
      end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] d, input bit track);
      int t = 0;
      req_valid = 1'b1; req_op = op; req_data = d;
      while (!req_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!req_ready) begin
        chk(g, "ready_timeout", 0, 1);
        return;
      end
      if (track) begin
        case (op)
          2'b00, 2'b10: ref_addr = d;
          2'b01: ref_mem[ref_addr] = d;
          default: rsp_q.push_back(ref_mem[ref_addr]);
        endcase
        frm_q.push_back({op[1], op, (op == 2'b11) ? 8'h00 : d});
      end
      @(negedge clk);
    endtask

    task automatic maybe_idle();
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        req_op = 2'($urandom); req_data = 8'($urandom);
        repeat ($urandom_range(1, 30)) @(negedge clk);
      end
    endtask

    initial begin
      logic [7:0] addrs[3];
      addrs[0] = 8'h10; addrs[1] = 8'h00; addrs[2] = 8'hFF;
      rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = 8'h00;
      for (int i = 0; i < 256; i++) begin
        ref_mem[i] = 8'(i * 37 + 11);
        sl_mem[i] = ref_mem[i];
      end
      ref_addr = 8'h00; sl_addr = 8'h00;
      repeat (3) @(negedge clk);
      chk(g, "reset_ready_low", req_ready, 0);
      chk(g, "reset_ss_n", ss_n, 1);
      chk(g, "reset_mosi", mosi, 0);
      rst = 1'b0;
      #1;
      chk(g, "init_ready", req_ready, 1);
      chk(g, "init_busy", busy, 0);
      chk(g, "init_rsp_valid", rsp_valid, 0);
      chk(g, "init_rsp_data", rsp_data, 0);
      for (int i = 0; i < 3; i++) begin
        send(2'b00, addrs[i], 1);
        send(2'b01, 8'h5A, 1);
        send(2'b10, addrs[i], 1);
        send(2'b11, 8'($urandom), 1);
      end
      send(2'b00, 8'hA5, 1);
      send(2'b01, 8'h3C, 1);
      send(2'b00, 8'h77, 1);
      send(2'b01, 8'hC3, 1);
      send(2'b10, 8'h77, 1);
      send(2'b11, 8'h00, 1);
      for (int i = 0; i < 40; i++) begin
        send(2'($urandom), 8'($urandom), 1);
        maybe_idle();
      end
      send(2'b11, 8'h00, 0);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk(g, "abort_ss_n", ss_n, 1);
      chk(g, "abort_mosi", mosi, 0);
      chk(g, "abort_ready", req_ready, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk(g, "post_ready", req_ready, 1);
      chk(g, "post_busy", busy, 0);
      chk(g, "post_rsp_valid", rsp_valid, 0);
      chk(g, "post_rsp_data", rsp_data, 0);
      send(2'b10, 8'h10, 1);
      send(2'b11, 8'h00, 1);
      send(2'b00, 8'hFF, 1);
      send(2'b11, 8'h00, 1);
      req_valid = 1'b0;
      repeat (60) @(negedge clk);
      chk(g, "rsp_q_left", rsp_q.size(), 0);
      chk(g, "frm_q_left", frm_q.size(), 0);
      done_cnt++;
    end
  end

  initial begin
    for (int i = 0; i < 50000 && done_cnt < 3; i++) @(posedge clk);
    if (done_cnt < 3) chk(-1, "finish_timeout", done_cnt, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
